// File: rtl/operand_fwd_unit.sv
// operand_fwd_unit: byte-granular operand bypass over a DEPTH-deep write-back history with load-use stall
module operand_fwd_unit #(
  parameter int DW    = 128,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              flush,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD*DW-1:0] rf_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW/8-1:0]   wb_byteen,
  input  logic [DW-1:0]     wb_data,
  input  logic              ex_load,
  input  logic [AW-1:0]     ex_wr_addr,
  output logic              stall,
  output logic              op_valid,
  output logic [NRD*DW-1:0] op_data,
  output logic [NRD-1:0]    fwd_hit
);
  localparam int BEW = DW / 8;
  logic [DEPTH-1:0] h_v;
  logic [AW-1:0]    h_a  [DEPTH];
  logic [BEW-1:0]   h_be [DEPTH];
  logic [DW-1:0]    h_d  [DEPTH];
  logic [NRD*DW-1:0] merged;
  logic [NRD-1:0]    hit;
  logic              dep;
  always_ff @(posedge clk) begin
    h_v[0]  <= !reset && wb_en;
    h_a[0]  <= wb_addr;
    h_be[0] <= wb_byteen;
    h_d[0]  <= wb_data;
    for (int k = 1; k < DEPTH; k++) begin
      h_v[k]  <= !reset && h_v[k-1];
      h_a[k]  <= h_a[k-1];
      h_be[k] <= h_be[k-1];
      h_d[k]  <= h_d[k-1];
    end
  end
  always_comb begin
    merged = rf_data;
    hit    = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int b = 0; b < BEW; b++) begin
        if (rd_en[p]) begin
          for (int k = DEPTH - 1; k >= 0; k--) begin
            if (h_v[k] && h_a[k] == rd_addr[p*AW +: AW] && h_be[k][b]) begin
              merged[p*DW + 8*b +: 8] = h_d[k][8*b +: 8];
              hit[p] = 1'b1;
            end
          end
          if (wb_en && wb_addr == rd_addr[p*AW +: AW] && wb_byteen[b]) begin
            merged[p*DW + 8*b +: 8] = wb_data[8*b +: 8];
            hit[p] = 1'b1;
          end
        end
      end
    end
  end
  always_comb begin
    dep = 1'b0;
    for (int p = 0; p < NRD; p++) dep = dep | (rd_en[p] && rd_addr[p*AW +: AW] == ex_wr_addr);
  end
  assign stall = !reset && id_valid && !flush && ex_load && dep;
  always_ff @(posedge clk) begin
    if (reset) begin
      op_valid <= 1'b0;
      op_data  <= '0;
      fwd_hit  <= '0;
    end else if (id_valid && !flush && !stall) begin
      op_valid <= 1'b1;
      op_data  <= merged;
      fwd_hit  <= hit;
    end else begin
      op_valid <= 1'b0;
    end
  end
endmodule
